decode_issue: RTL and testbench

//  Decode/issue stage directly upstream of the 16x16 register file. Holds one fetched

---
 rtl/cpu_pkg.sv | 42 ++++
 rtl/decode_issue_if.sv | 33 +++
 rtl/decode_scoreboard.sv | 29 ++
 rtl/decode_issue.sv | 114 +++++++++++
 tb/tb_decode_issue.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, instruction field positions, and operand-usage helpers.
// Decode, execute and writeback all import this package.
package cpu_pkg;
  localparam logic [3:0] OP_NOP    = 4'h0;
  localparam logic [3:0] OP_ALU_LO = 4'h1;
  localparam logic [3:0] OP_ALU_HI = 4'h7;
  localparam logic [3:0] OP_ADDI   = 4'h8;
  localparam logic [3:0] OP_LOAD   = 4'h9;
  localparam logic [3:0] OP_STORE  = 4'hA;
  localparam logic [3:0] OP_BEQ    = 4'hB;
  localparam logic [3:0] OP_HALT   = 4'hF;

  localparam int INSTR_W = 16;
  localparam int FIELD_W = 4;
  localparam int OP_LSB  = 12;
  localparam int RD_LSB  = 8;
  localparam int RS1_LSB = 4;
  localparam int RS2_LSB = 0;

  typedef enum logic {ST_RUN, ST_HALTED} dec_state_t;

  function automatic logic is_writer(input logic [3:0] op);
    return (op >= OP_ALU_LO) && (op <= OP_LOAD);
  endfunction

  function automatic logic uses_rs1(input logic [3:0] op);
    return (op >= OP_ALU_LO) && (op <= OP_BEQ);
  endfunction

  function automatic logic uses_rs2(input logic [3:0] op);
    return (op >= OP_ALU_LO) && (op <= OP_ALU_HI);
  endfunction

  function automatic logic uses_rd(input logic [3:0] op);
    return (op == OP_STORE) || (op == OP_BEQ);
  endfunction

  // C..E have no defined behaviour; they flow down the pipe as NOPs.
  function automatic logic is_illegal(input logic [3:0] op);
    return (op > OP_BEQ) && (op < OP_HALT);
  endfunction
endpackage

// File: rtl/decode_issue_if.sv
// Decode/issue stage bus: fetch handshake, regfile read controls, execute issue and writeback retire.
interface decode_issue_if #(
  parameter int DATA_W = 16,
  parameter int AW     = 4
);
  logic              instr_valid;
  logic [15:0]       instr;
  logic              instr_ready;
  logic              flush;
  logic              regread;
  logic [AW-1:0]     readregsrc1;
  logic [AW-1:0]     readregsrc2;
  logic [AW-1:0]     readregsrc3;
  logic              ex_valid;
  logic              ex_ready;
  logic [3:0]        ex_op;
  logic [AW-1:0]     ex_dst;
  logic [DATA_W-1:0] ex_imm;
  logic              wb_valid;
  logic [AW-1:0]     wb_dst;

  modport master (
    input  instr_valid, instr, flush, ex_ready, wb_valid, wb_dst,
    output instr_ready, regread, readregsrc1, readregsrc2, readregsrc3,
           ex_valid, ex_op, ex_dst, ex_imm
  );

  modport slave (
    output instr_valid, instr, flush, ex_ready, wb_valid, wb_dst,
    input  instr_ready, regread, readregsrc1, readregsrc2, readregsrc3,
           ex_valid, ex_op, ex_dst, ex_imm
  );
endinterface

// File: rtl/decode_scoreboard.sv
// Per-register pending-write bits with set/clear and a three-port busy lookup.
// Set and clear of the same register in one cycle leaves the bit set.
module decode_scoreboard #(
  parameter int NREG = 16,
  parameter int AW   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               set_en,
  input  logic [AW-1:0]      set_addr,
  input  logic               clr_en,
  input  logic [AW-1:0]      clr_addr,
  input  logic [2:0][AW-1:0] rd_addr,
  output logic [2:0]         busy
);
  logic [NREG-1:0] sb;

  for (genvar i = 0; i < NREG; i++) begin : g_bit
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                 sb[i] <= 1'b0;
      else if (set_en && (set_addr == AW'(i)))    sb[i] <= 1'b1;
      else if (clr_en && (clr_addr == AW'(i)))    sb[i] <= 1'b0;
    end
  end

  for (genvar k = 0; k < 3; k++) begin : g_look
    assign busy[k] = sb[rd_addr[k]];
  end
endmodule

// File: rtl/decode_issue.sv
// Decode/issue stage: one-instruction slot, scoreboard hazard check, issue register to execute.
// Optional DECODE_STALL_CNT_EN adds a saturating hazard-stall counter output.
module decode_issue
  import cpu_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int NREG   = 16,
  parameter int AW     = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  decode_issue_if.master bus,
  output logic           halted
`ifdef DECODE_STALL_CNT_EN
  ,
  output logic [15:0]    stall_cnt
`endif
);
  dec_state_t state, state_nxt;

  logic               d_valid;
  logic [INSTR_W-1:0] d_instr;
  logic [3:0]         op;
  logic [AW-1:0]      rd, rs1, rs2;
  logic [3:0]         imm4;
  logic [2:0]         busy;
  logic               run, hazard, issue, instr_ready;

  logic               ex_valid_q;
  logic [3:0]         ex_op_q;
  logic [AW-1:0]      ex_dst_q;
  logic [DATA_W-1:0]  ex_imm_q;

  assign op   = d_instr[OP_LSB  +: FIELD_W];
  assign rd   = d_instr[RD_LSB  +: AW];
  assign rs1  = d_instr[RS1_LSB +: AW];
  assign rs2  = d_instr[RS2_LSB +: AW];
  assign imm4 = d_instr[RS2_LSB +: FIELD_W];

  decode_scoreboard #(.NREG(NREG), .AW(AW)) u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_en   (issue & is_writer(op)),
    .set_addr (rd),
    .clr_en   (bus.wb_valid),
    .clr_addr (bus.wb_dst),
    .rd_addr  ({rd, rs2, rs1}),
    .busy     (busy)
  );

  // A writer's rd is checked too, so WAW waits like RAW.
  assign hazard = (uses_rs1(op) & busy[0]) | (uses_rs2(op) & busy[1]) |
                  ((uses_rd(op) | is_writer(op)) & busy[2]);

  always_comb begin
    state_nxt   = state;
    run         = (state == ST_RUN);
    issue       = d_valid & ~hazard & ~bus.flush & run & (~ex_valid_q | bus.ex_ready);
    // Flush empties the slot this cycle, so a new fetch can land in the same edge.
    instr_ready = run & (~d_valid | issue | bus.flush);
    if (issue && (op == OP_HALT)) state_nxt = ST_HALTED;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_RUN;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_valid <= 1'b0;
      d_instr <= '0;
    end else if (bus.instr_valid && instr_ready) begin
      d_valid <= 1'b1;
      d_instr <= bus.instr;
    end else if (issue || bus.flush) begin
      d_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q <= 1'b0;
      ex_op_q    <= '0;
      ex_dst_q   <= '0;
      ex_imm_q   <= '0;
    end else if (issue) begin
      ex_valid_q <= 1'b1;
      ex_op_q    <= is_illegal(op) ? OP_NOP : op;
      ex_dst_q   <= rd;
      ex_imm_q   <= {{(DATA_W-4){imm4[3]}}, imm4};
    end else if (bus.ex_ready) begin
      ex_valid_q <= 1'b0;
    end
  end

`ifdef DECODE_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                     stall_cnt <= '0;
    else if (d_valid && hazard && run && (stall_cnt != 16'hFFFF)) stall_cnt <= stall_cnt + 16'd1;
  end
`endif

  assign bus.instr_ready = instr_ready;
  assign bus.regread     = d_valid & run;
  assign bus.readregsrc1 = rs1;
  assign bus.readregsrc2 = rs2;
  assign bus.readregsrc3 = rd;
  assign bus.ex_valid    = ex_valid_q;
  assign bus.ex_op       = ex_op_q;
  assign bus.ex_dst      = ex_dst_q;
  assign bus.ex_imm      = ex_imm_q;
  assign halted          = (state == ST_HALTED);
endmodule

// File: tb/tb_decode_issue.sv
// Scoreboard bench for decode_issue: expected issues are queued by stimulus, a monitor pops on ex handshake.
module tb_decode_issue;
  import cpu_pkg::*;

  typedef struct packed {
    logic [3:0]  op;
    logic [3:0]  dst;
    logic [15:0] imm;
  } exp_t;

  logic clk, rst_n, halted;
`ifdef DECODE_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif
  int total = 0;
  int bad   = 0;
  exp_t exp_q[$];

  decode_issue_if #(.DATA_W(16), .AW(4)) bus ();

  decode_issue #(.DATA_W(16), .NREG(16), .AW(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus),
    .halted (halted)
`ifdef DECODE_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
    end
  endtask

  task automatic push(input logic [3:0] op, input logic [3:0] dst, input logic [15:0] imm);
    exp_t e;
    e.op = op; e.dst = dst; e.imm = imm;
    exp_q.push_back(e);
  endtask

  // Monitor: every ex handshake must match the oldest expected issue.
  always @(negedge clk) begin
    if (rst_n && bus.ex_valid && bus.ex_ready) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL ex_unexpected got op=%h dst=%h imm=%h exp=none", bus.ex_op, bus.ex_dst, bus.ex_imm);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("ex_issue", {8'h0, bus.ex_op, bus.ex_dst, bus.ex_imm}, {8'h0, e});
      end
    end
  end

  // All tasks start and end 1ns after a rising edge.
  task automatic send(input logic [15:0] ins);
    int n = 0;
    bus.instr_valid = 1'b1;
    bus.instr       = ins;
    @(negedge clk);
    while (!bus.instr_ready && n < 50) begin @(negedge clk); n++; end
    if (!bus.instr_ready) begin
      total++; bad++;
      $display("FAIL send_timeout got=ready0 exp=ready1 instr=%h", ins);
    end
    @(posedge clk); #1;
    bus.instr_valid = 1'b0;
  endtask

  task automatic wb(input logic [3:0] r);
    bus.wb_valid = 1'b1;
    bus.wb_dst   = r;
    @(posedge clk); #1;
    bus.wb_valid = 1'b0;
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while (exp_q.size() != 0 && n < 40) begin @(negedge clk); n++; end
    chk(nm, exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  // ADD r3, then dependent SUB r4 stalled until wb r3 in the 4th stall cycle.
  task automatic raw_seq();
    send(16'h1312); push(4'h1, 4'h3, 16'h0002);
    send(16'h2435); push(4'h2, 4'h4, 16'h0005);
    @(negedge clk); chk("raw_regread", bus.regread, 1);
    repeat (2) begin
      @(negedge clk);
      chk("raw_stall", bus.ex_valid, 0);
      chk("raw_regread", bus.regread, 1);
    end
    @(posedge clk); #1;
    bus.wb_valid = 1'b1; bus.wb_dst = 4'h3;
    @(negedge clk); chk("raw_wb_cycle", bus.ex_valid, 0);
    @(posedge clk); #1;
    bus.wb_valid = 1'b0;
    @(negedge clk);
    chk("raw_n1_noissue", bus.ex_valid, 0);
    chk("raw_regread", bus.regread, 1);
    @(negedge clk); chk("raw_issue", bus.ex_valid, 1);
    @(posedge clk); #1;
    wb(4'h4);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    bus.instr_valid = 1'b0; bus.instr = '0; bus.flush = 1'b0;
    bus.ex_ready = 1'b1; bus.wb_valid = 1'b0; bus.wb_dst = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ex_valid", bus.ex_valid, 0);
    chk("rst_instr_ready", bus.instr_ready, 1);
    chk("rst_regread", bus.regread, 0);
    chk("rst_halted", halted, 0);
    chk("rst_ex_fields", {8'h0, bus.ex_op, bus.ex_dst, bus.ex_imm}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    raw_seq();

    // Backpressure: ex held for 3 cycles, slot fills behind it.
    bus.ex_ready = 1'b0;
    send(16'h8607); push(OP_ADDI, 4'h6, 16'h0007);
    send(16'h8A1F); push(OP_ADDI, 4'hA, 16'hFFFF);
    repeat (3) begin
      @(negedge clk);
      chk("bp_ex_valid", bus.ex_valid, 1);
      chk("bp_ex_hold", {8'h0, bus.ex_op, bus.ex_dst, bus.ex_imm}, 32'h0086_0007);
      chk("bp_instr_ready", bus.instr_ready, 0);
    end
    @(posedge clk); #1;
    bus.ex_ready = 1'b1;
    drain("bp_drain");
    wb(4'h6); wb(4'hA);

    // Set/clear race on r3: set must win, so the reader of r3 stalls.
    send(16'h8301); push(OP_ADDI, 4'h3, 16'h0001);
    wb(4'h3);
    send(16'h1530); push(4'h1, 4'h5, 16'h0000);
    repeat (3) begin
      @(negedge clk); chk("race_set_wins", bus.ex_valid, 0);
    end
    @(posedge clk); #1;
    wb(4'h3);
    drain("race_drain");
    wb(4'h5);

    // Flush kills held ADD; ADDI r7 captured in the flush cycle.
    bus.instr_valid = 1'b1; bus.instr = 16'h1120;
    @(negedge clk); chk("fl_ready", bus.instr_ready, 1);
    @(posedge clk); #1;
    bus.flush = 1'b1; bus.instr = 16'h8702;
    @(negedge clk); chk("fl_capture_ready", bus.instr_ready, 1);
    @(posedge clk); #1;
    bus.flush = 1'b0; bus.instr_valid = 1'b0;
    push(OP_ADDI, 4'h7, 16'h0002);
    @(negedge clk); chk("fl_no_issue", bus.ex_valid, 0);
    drain("fl_drain");
    wb(4'h7);

    // Async reset while ADD is in ex and SUB is stalled on r3.
    send(16'h1312); push(4'h1, 4'h3, 16'h0002);
    send(16'h2435);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ex_valid", bus.ex_valid, 0);
    chk("arst_instr_ready", bus.instr_ready, 1);
    chk("arst_regread", bus.regread, 0);
    chk("arst_ex_fields", {8'h0, bus.ex_op, bus.ex_dst, bus.ex_imm}, 0);
    chk("arst_q_empty", exp_q.size(), 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
`ifdef DECODE_STALL_CNT_EN
    chk("stall_cnt_rst", stall_cnt, 0);
`endif
    send(16'h2435); push(4'h2, 4'h4, 16'h0005);
    @(negedge clk);
    @(negedge clk); chk("arst_sb_clear", bus.ex_valid, 1);
    @(posedge clk); #1;
    wb(4'h4);

`ifdef DECODE_STALL_CNT_EN
    raw_seq();
    chk("stall_cnt_4", stall_cnt, 4);
`endif

    // HALT: halted next cycle, nothing further accepted or issued.
    send(16'hF000); push(OP_HALT, 4'h0, 16'h0000);
    @(negedge clk); chk("halt_pre", halted, 0);
    @(negedge clk);
    chk("halt_set", halted, 1);
    chk("halt_ready", bus.instr_ready, 0);
    bus.instr_valid = 1'b1; bus.instr = 16'h8101;
    repeat (5) begin
      @(negedge clk);
      chk("halt_ready_hold", bus.instr_ready, 0);
      chk("halt_no_issue", bus.ex_valid, 0);
      chk("halt_regread", bus.regread, 0);
      chk("halt_hold", halted, 1);
    end
    bus.instr_valid = 1'b0;
    chk("final_q_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
